// File: rtl/load_align_unit.sv
// Purpose : multi-cycle load engine; splits word-crossing loads into two reads, merges and sign/zero-extends.
// Latency : accept->rsp_valid 3 cycles (single word), 4 cycles (crossing), 2 cycles (fault).
// Backpressure: one request at a time; req_ready only in IDLE; response held in RESP until rsp_ready.
//
// Ports:
//   CPU_CLK, CPU_RST            clock, asynchronous active-high reset
//   req_valid/req_ready         request handshake; req_addr (byte), req_type (load mode), req_rd (tag)
//   mem_rd_en/mem_addr          word read strobe and word address; mem_rdata arrives one cycle later
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_rd, rsp_fault
//   busy                        unit is not idle
module load_align_unit #(
    parameter int ADDR_W             = 32,
    parameter bit SUPPORT_MISALIGNED = 1'b1
) (
    input  logic              CPU_CLK,
    input  logic              CPU_RST,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_type,
    input  logic [4:0]        req_rd,
    output logic              mem_rd_en,
    output logic [ADDR_W-3:0] mem_addr,
    input  logic [31:0]       mem_rdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              rsp_fault,
    output logic              busy
);

    localparam int WW = ADDR_W - 2;

    // Load mode encodings shared with the pipeline's parameter file.
    localparam logic [2:0] T_NOREG = 3'd0;
    localparam logic [2:0] T_LB    = 3'd1;
    localparam logic [2:0] T_LH    = 3'd2;
    localparam logic [2:0] T_LW    = 3'd3;
    localparam logic [2:0] T_LBU   = 3'd4;
    localparam logic [2:0] T_LHU   = 3'd5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD0   = 3'd1,
        CAP0  = 3'd2,
        CAP1  = 3'd3,
        FAULT = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t          state;
    logic [WW-1:0]   word_q;
    logic [1:0]      off_q;
    logic [2:0]      type_q;
    logic            cross_q;
    logic [31:0]     lo_q;

    logic            type_ok;
    logic [2:0]      req_size;
    logic [2:0]      req_end;
    logic            req_cross;
    logic            req_fault;
    logic [WW-1:0]   word_nxt;

    // Size in bytes; invalid codes get size 1 so they never look like a crossing.
    always_comb begin
        type_ok  = 1'b1;
        req_size = 3'd1;
        case (req_type)
            T_LB, T_LBU: req_size = 3'd1;
            T_LH, T_LHU: req_size = 3'd2;
            T_LW:        req_size = 3'd4;
            default:     type_ok  = 1'b0;
        endcase
    end

    // off + size reaches at most 7, so three bits never overflow.
    assign req_end   = {1'b0, req_addr[1:0]} + req_size;
    assign req_cross = (req_end > 3'd4);
    assign req_fault = !type_ok || (req_cross && !SUPPORT_MISALIGNED);

    // Second word of a crossing load; the all-ones word wraps to zero.
    assign word_nxt = word_q + {{(WW-1){1'b0}}, 1'b1};

    // Select the addressed bytes from the {hi, lo} pair, then extend.
    function automatic logic [31:0] merge(input logic [63:0] pair,
                                          input logic [1:0]  off,
                                          input logic [2:0]  t);
        logic [31:0] m;
        m = pair[{off, 3'b000} +: 32];
        case (t)
            T_LB:    merge = {{24{m[7]}}, m[7:0]};
            T_LH:    merge = {{16{m[15]}}, m[15:0]};
            T_LBU:   merge = {24'b0, m[7:0]};
            T_LHU:   merge = {16'b0, m[15:0]};
            default: merge = m;
        endcase
    endfunction

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state     <= IDLE;
            word_q    <= '0;
            off_q     <= '0;
            type_q    <= T_NOREG;
            cross_q   <= 1'b0;
            lo_q      <= '0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            rsp_fault <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        word_q  <= req_addr[ADDR_W-1:2];
                        off_q   <= req_addr[1:0];
                        type_q  <= req_type;
                        cross_q <= req_cross;
                        rsp_rd  <= req_rd;
                        state   <= req_fault ? FAULT : RD0;
                    end
                end
                RD0: state <= CAP0;
                CAP0: begin
                    lo_q <= mem_rdata;
                    if (cross_q) begin
                        state <= CAP1;
                    end else begin
                        rsp_data  <= merge({32'b0, mem_rdata}, off_q, type_q);
                        rsp_fault <= 1'b0;
                        state     <= RESP;
                    end
                end
                CAP1: begin
                    rsp_data  <= merge({mem_rdata, lo_q}, off_q, type_q);
                    rsp_fault <= 1'b0;
                    state     <= RESP;
                end
                FAULT: begin
                    rsp_data  <= '0;
                    rsp_fault <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // All handshake/strobe outputs decode from registered state only.
    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign busy      = (state != IDLE);
    assign mem_rd_en = (state == RD0) || ((state == CAP0) && cross_q);
    assign mem_addr  = (state == RD0)               ? word_q   :
                       ((state == CAP0) && cross_q) ? word_nxt : '0;

endmodule
